// File: rtl/uart_frame_pkg.sv
// Shared encodings for the UART frame decoder: FSM states, error causes
// and the default start-of-frame marker.
package uart_frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHECK
    } frame_state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_LENGTH   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_timeout.sv
// Inter-byte idle counter. expired fires on the edge where the count steps
// into TIMEOUT_CYCLES-1, so the decoder's registered error lands on that same edge.
module uart_frame_timeout #(
    parameter int TIMEOUT_CYCLES = 12000
) (
    input  logic i_master_clk,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST     = W'(TIMEOUT_CYCLES - 1);
    localparam logic [W-1:0] PRE_LAST = W'(TIMEOUT_CYCLES - 2);

    logic [W-1:0] count;

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != LAST) begin
            count <= count + W'(1);
        end
    end

    // A clear in the same cycle always suppresses expiry, so an arriving byte wins.
    assign expired = enable && !clear && (count == PRE_LAST);

endmodule

// File: rtl/uart_frame_decoder.sv
// Decodes SYNC / LEN / payload / XOR-checksum frames from a byte stream,
// streaming payload bytes out as they arrive.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int         CLOCK_FREQ     = 12000000,
    parameter int         TIMEOUT_CYCLES = 12000,
    parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
    parameter int         MAX_LEN        = 16
) (
    input  logic       i_master_clk,
    input  logic       i_reset,
    input  logic [7:0] i_rx_data,
    input  logic       i_rx_data_valid,
    output logic [7:0] o_payload_data,
    output logic       o_payload_valid,
    output logic       o_frame_start,
    output logic       o_frame_done,
    output logic       o_frame_error,
    output logic [1:0] o_error_code
);

    if (CLOCK_FREQ < 1 || TIMEOUT_CYCLES < 2 || MAX_LEN < 1 || MAX_LEN > 255) begin : g_param_check
        $error("uart_frame_decoder: parameter out of range");
    end

    localparam logic [7:0] MAX_LEN_BYTE = 8'(MAX_LEN);

    frame_state_t state;
    logic [7:0]   remaining;
    logic [7:0]   running_xor;
    logic         timeout_expired;

    uart_frame_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_master_clk(i_master_clk),
        .i_reset     (i_reset),
        .clear       (i_rx_data_valid || state == ST_IDLE),
        .enable      (state != ST_IDLE),
        .expired     (timeout_expired)
    );

    always_ff @(posedge i_master_clk or posedge i_reset) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            remaining       <= 8'd0;
            running_xor     <= 8'd0;
            o_payload_data  <= 8'd0;
            o_payload_valid <= 1'b0;
            o_frame_start   <= 1'b0;
            o_frame_done    <= 1'b0;
            o_frame_error   <= 1'b0;
            o_error_code    <= ERR_NONE;
        end else begin
            o_payload_valid <= 1'b0;
            o_frame_start   <= 1'b0;
            o_frame_done    <= 1'b0;
            o_frame_error   <= 1'b0;

            if (timeout_expired) begin
                o_frame_error <= 1'b1;
                o_error_code  <= ERR_TIMEOUT;
                state         <= ST_IDLE;
                remaining     <= 8'd0;
                running_xor   <= 8'd0;
            end else if (i_rx_data_valid) begin
                unique case (state)
                    ST_IDLE: begin
                        if (i_rx_data == SYNC_BYTE) begin
                            state <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (i_rx_data > MAX_LEN_BYTE) begin
                            o_frame_error <= 1'b1;
                            o_error_code  <= ERR_LENGTH;
                            state         <= ST_IDLE;
                            running_xor   <= 8'd0;
                        end else begin
                            o_frame_start <= 1'b1;
                            running_xor   <= i_rx_data;
                            remaining     <= i_rx_data;
                            state         <= (i_rx_data == 8'd0) ? ST_CHECK : ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        // SYNC_BYTE values here are ordinary data; no mid-frame resync.
                        o_payload_data  <= i_rx_data;
                        o_payload_valid <= 1'b1;
                        running_xor     <= running_xor ^ i_rx_data;
                        remaining       <= remaining - 8'd1;
                        if (remaining == 8'd1) begin
                            state <= ST_CHECK;
                        end
                    end
                    ST_CHECK: begin
                        if (i_rx_data == running_xor) begin
                            o_frame_done <= 1'b1;
                            o_error_code <= ERR_NONE;
                        end else begin
                            o_frame_error <= 1'b1;
                            o_error_code  <= ERR_CHECKSUM;
                        end
                        state       <= ST_IDLE;
                        remaining   <= 8'd0;
                        running_xor <= 8'd0;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 12000000, master clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 12000, maximum number of idle clocks allowed between bytes inside a frame.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 SHALL have parameter MAX_LEN, default 16, maximum payload length in bytes (range 1..255).
REQ-005 SHALL have port i_master_clk  input  1  the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_rx_data  input  8  received byte from the UART receiver.
REQ-008 SHALL have port i_rx_data_valid  input  1  one-cycle pulse qualifying i_rx_data.
REQ-009 SHALL have port o_payload_data  output  8  payload byte.
REQ-010 SHALL have port o_payload_valid  output  1  one-cycle pulse qualifying o_payload_data.
REQ-011 SHALL have port o_frame_start  output  1  one-cycle pulse when a valid LEN byte is accepted.
REQ-012 SHALL have port o_frame_done  output  1  one-cycle pulse when the checksum matches.
REQ-013 SHALL have port o_frame_error  output  1  one-cycle pulse when the frame is aborted.
REQ-014 SHALL have port o_error_code  output  2  cause of the last error: 0 none, 1 checksum, 2 length, 3 timeout; holds its value until the next done or error.

Function
REQ-015 Frame format SHALL be: SYNC_BYTE, LEN, then LEN payload bytes, then CHK, where CHK = XOR of LEN and all payload bytes.
REQ-016 State machine SHALL have states IDLE, LEN, PAYLOAD and CHECK, and SHALL act only on cycles where i_rx_data_valid=1, except for the timeout.
REQ-017 In IDLE, a byte equal to SYNC_BYTE SHALL move to LEN; any other byte SHALL be silently ignored.
REQ-018 In LEN:
- LEN > MAX_LEN -> error code 2, go to IDLE, no o_frame_start.
- LEN = 0 -> o_frame_start, go to CHECK.
- Otherwise -> o_frame_start, load the remaining-byte counter with LEN, go to PAYLOAD.
REQ-019 In PAYLOAD, each byte SHALL be output on o_payload_data with o_payload_valid exactly one cycle after its i_rx_data_valid; the counter decrements, and reaching 0 moves to CHECK.
REQ-020 In CHECK:
- Byte equal to the running XOR -> o_frame_done, o_error_code=0.
- Otherwise -> o_frame_error, o_error_code=1.
- Either way, return to IDLE.
REQ-021 Payload SHALL be streamed, not buffered; the consumer discards the payload already received when o_frame_error is asserted.
REQ-022 The running XOR SHALL be 8 bits wide, seeded with the LEN byte, and cleared on entry to IDLE.
REQ-023 Timeout counter SHALL clear on every i_rx_data_valid and in IDLE, and SHALL increment otherwise.
REQ-024 When the counter reaches TIMEOUT_CYCLES-1 outside IDLE, the block SHALL raise o_frame_error with o_error_code=3 and go to IDLE.
REQ-025 If a byte arrives in the same cycle the timeout would fire, the byte SHALL win and no timeout SHALL occur.
REQ-026 A SYNC_BYTE value seen in LEN, PAYLOAD or CHECK SHALL be treated as data; there is no resynchronisation mid-frame.
REQ-027 All output pulses SHALL be registered, exactly one cycle wide, and o_frame_done and o_frame_error SHALL never be asserted in the same cycle.

Reset
REQ-028 Reset SHALL force state IDLE, all counters 0, the XOR 0, o_payload_data 0, all pulse outputs 0 and o_error_code 0.
REQ-029 Reset asserted mid-frame SHALL abandon the frame without o_frame_error; the first frame after release requires a fresh SYNC_BYTE.

Structure
REQ-030 Package uart_frame_pkg SHALL hold the state encodings, the error-code constants and the default SYNC_BYTE.
REQ-031 The timeout counter SHALL be sub-module uart_frame_timeout, with parameter TIMEOUT_CYCLES and ports clear, enable and expired; the counter width is $clog2(TIMEOUT_CYCLES).
REQ-032 Widths SHALL derive from parameters; the remaining-byte counter is 8 bits.

Verification
REQ-033 Good frame: A5 03 11 22 33 03 -> o_frame_start once; payload 11, 22, 33, each one cycle after its input; o_frame_done; o_error_code=0.
REQ-034 Bad checksum: A5 03 11 22 33 04 -> three payload pulses, then o_frame_error with o_error_code=1, then IDLE.
REQ-035 Length limits with MAX_LEN=16:
- A5 11 -> o_frame_error, code 2, no o_frame_start.
- A5 00 00 -> o_frame_start, then o_frame_done, with zero payload pulses.
REQ-036 Timeout: A5 02 11 then silence -> o_frame_error with code 3 exactly TIMEOUT_CYCLES-1 clocks after the last valid; then A5 01 7E 7F -> done.
REQ-037 Leading garbage 00 FF 5A before A5 01 A5 A4 -> garbage ignored; payload A5 output as data; o_frame_done.
REQ-038 Reset pulsed after A5 02 11 -> all outputs 0, no error pulse; a following complete frame decodes correctly.
